alu_share_ctrl: RTL

Arbitrated front-end that shares a single 4-bit ALU (`alu_4bit`, instantiated inside) between NUM_REQ requesters. Each requester presents an operand pair and an opcode with a valid/ready handshake. The controller grants requesters round-robin, registers the operands and then the ALU outputs, and returns the result tagged with the requester index on one shared response channel with backpressure.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_4bit.sv | 37 +++
 rtl/alu_rr_arbiter.sv | 46 ++++
 rtl/alu_share_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU front-end: opcodes, FSM encoding, defaults.
package alu_pkg;

    localparam int DEFAULT_NUM_REQ = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU; carry carries add carry-out, borrow, or the shifted-out bit.
module alu_4bit
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [3:0] result,
    output logic       carry,
    output logic       zero
);

    logic [4:0] sum5;
    logic [4:0] diff5;

    assign sum5  = {1'b0, a} + {1'b0, b};
    assign diff5 = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = 4'd0;
        carry  = 1'b0;
        case (op)
            OP_ADD: {carry, result} = sum5;
            OP_SUB: {carry, result} = diff5;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin result = {a[2:0], 1'b0}; carry = a[3]; end
            OP_SHR: begin result = {1'b0, a[3:1]}; carry = a[0]; end
            default: ;
        endcase
    end

    assign zero = (result == 4'd0);

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from the pointer upward,
// pointer advances past the winner only when a grant is taken.
module alu_rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    logic [ID_W-1:0] ptr;

    always_comb begin
        int              s;
        logic [ID_W-1:0] idx;
        grant  = '0;
        gnt_id = '0;
        any    = 1'b0;
        s      = 0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            s = int'(ptr) + k;
            if (s >= N) s = s - N;
            idx = ID_W'(s);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && any) begin
            ptr <= (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one 4-bit ALU among NUM_REQ requesters: round-robin accept, execute, tagged response.
// Optional completed-operation counter enabled by defining ALU_SHARE_STATS_EN.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    input  logic [3*NUM_REQ-1:0] req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [3:0]           rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_zero,
    output logic                 busy,
    output logic [15:0]          op_count
);

    state_t              state;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     gnt_id;
    logic                any_req;
    logic                idle;

    logic [3:0]          a_p0;
    logic [3:0]          b_p0;
    logic [2:0]          op_p0;
    logic [ID_W-1:0]     id_p0;

    logic [3:0]          alu_result;
    logic                alu_carry;
    logic                alu_zero;

    assign idle = (state == ST_IDLE);

    alu_rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .en     (idle),
        .grant  (grant),
        .gnt_id (gnt_id),
        .any    (any_req)
    );

    // Grant is only visible while idle and out of reset, so nothing is offered mid-operation.
    assign req_ready = (idle && !rst) ? grant : '0;

    // Stage p0: latch the granted requester's payload on accept
    always_ff @(posedge clk) begin
        if (idle && any_req) begin
            a_p0  <= req_a[4*gnt_id +: 4];
            b_p0  <= req_b[4*gnt_id +: 4];
            op_p0 <= req_op[3*gnt_id +: 3];
            id_p0 <= gnt_id;
        end
    end

    alu_4bit u_alu (
        .a      (a_p0),
        .b      (b_p0),
        .op     (op_p0),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Stage p1: register ALU outputs and hold the response until it is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= 4'd0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state <= ST_EXEC;
                        busy  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_carry  <= alu_carry;
                    rsp_zero   <= alu_zero;
                    rsp_id     <= id_p0;
                    rsp_valid  <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_SHARE_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] op_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt <= 16'd0;
        end else if (rsp_valid && rsp_ready) begin
            op_cnt <= sat_inc(op_cnt);
        end
    end

    assign op_count = op_cnt;
`else
    assign op_count = 16'd0;
`endif

endmodule
